// File: rtl/tube_pkg.sv
// rtl/tube_pkg.sv - shared constants, state enum and helpers for the tube field
// Contents: LFSR seed and tap mask, gap-shrink constants (used when
// TUBE_GAP_SHRINK_EN is defined), controller state enum, respawn popcount.
package tube_pkg;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 -> state bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int GAP_INIT = 60;
    localparam int GAP_STEP = 4;
    localparam int GAP_MIN  = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } state_t;

    // Number of tubes respawning this cycle; the vector is padded to 8 bits.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Fibonacci LFSR
// Ports: clk10 clock; clr sync active-high reset (loads the seed);
//        state current 16-bit register value, advances every cycle.
module lfsr16
    import tube_pkg::*;
(
    input  logic        clk10,
    input  logic        clr,
    output logic [15:0] state
);

    always_ff @(posedge clk10) begin
        if (clr) begin
            state <= LFSR_SEED;
        end else begin
            state <= {state[14:0], ^(state & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/tube_field_ctrl.sv
// rtl/tube_field_ctrl.sv - scrolling tube field: motion, respawn, scoring, levels
// Optional feature macro: TUBE_GAP_SHRINK_EN (adds gap_half output).
// Ports: clk10 game clock; clr sync active-high reset; start level pulse
//        (IDLE->RUN, FROZEN->IDLE); game_end freezes motion while high;
//        tube_x/tube_y packed positions, tube i at [i*X_W +: X_W];
//        score saturating pass count; speed pixels per tick;
//        pass_pulse one cycle when any tube respawned; running high in RUN;
//        gap_half (macro only) field-wide half opening height.
module tube_field_ctrl
    import tube_pkg::*;
#(
    parameter int N_TUBES    = 3,
    parameter int X_W        = 10,
    parameter int X_INIT0    = 404,
    parameter int X_SPACING  = 250,
    parameter int X_LEFT     = 114,
    parameter int X_RESPAWN  = 904,
    parameter int Y_MIN      = 150,
    parameter int RAND_W     = 7,
    parameter int Y_INIT     = 200,
    parameter int SPEED_INIT = 5,
    parameter int SPEED_MAX  = 12,
    parameter int LEVEL_STEP = 10,
    parameter int SCORE_W    = 8
) (
    input  logic                   clk10,
    input  logic                   clr,
    input  logic                   start,
    input  logic                   game_end,
    output logic [N_TUBES*X_W-1:0] tube_x,
    output logic [N_TUBES*X_W-1:0] tube_y,
    output logic [SCORE_W-1:0]     score,
    output logic [4:0]             speed,
    output logic                   pass_pulse,
    output logic                   running
`ifdef TUBE_GAP_SHRINK_EN
    ,output logic [X_W-1:0]        gap_half
`endif
);

    localparam logic [X_W-1:0]     X_LEFT_V    = X_W'(X_LEFT);
    localparam logic [X_W-1:0]     X_RESPAWN_V = X_W'(X_RESPAWN);
    localparam logic [X_W-1:0]     Y_MIN_V     = X_W'(Y_MIN);
    localparam logic [X_W-1:0]     Y_INIT_V    = X_W'(Y_INIT);
    localparam logic [4:0]         SPEED_INIT_V = 5'(SPEED_INIT);
    localparam logic [4:0]         SPEED_MAX_V  = 5'(SPEED_MAX);
    localparam logic [SCORE_W-1:0] LEVEL_V     = SCORE_W'(LEVEL_STEP);
    localparam logic [SCORE_W:0]   SCORE_MAX   = {1'b0, {SCORE_W{1'b1}}};

    state_t        state;
    logic [15:0]   lfsr;
    logic [7:0]    respawn_vec;
    logic [3:0]    k;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_new;
    logic          level_up;
    logic          restart;
    logic [X_W-1:0] x_next [N_TUBES];
    logic [X_W-1:0] y_next [N_TUBES];

    lfsr16 u_lfsr (
        .clk10 (clk10),
        .clr   (clr),
        .state (lfsr)
    );

    // Leaving FROZEN reloads the power-on field, but the LFSR keeps running
    // so the next game gets different gap heights.
    assign restart = (state == FROZEN) && start && !game_end;

    always_comb begin
        logic [15:0] sh;
        sh          = '0;
        respawn_vec = '0;
        for (int i = 0; i < N_TUBES; i++) begin
            respawn_vec[i] = (tube_x[i*X_W +: X_W] <= X_LEFT_V);
            // Shifting by the tube index gives each tube its own offset
            // when several respawn on the same edge.
            sh = lfsr >> i;
            if (respawn_vec[i]) begin
                x_next[i] = X_RESPAWN_V;
                y_next[i] = Y_MIN_V + X_W'(sh[RAND_W-1:0]);
            end else begin
                x_next[i] = tube_x[i*X_W +: X_W] - X_W'(speed);
                y_next[i] = tube_y[i*X_W +: X_W];
            end
        end
    end

    assign k         = popcount8(respawn_vec);
    assign score_sum = {1'b0, score} + (SCORE_W+1)'(k);
    assign score_new = (score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0]
                                               : score_sum[SCORE_W-1:0];
    // Crossing a level boundary; a saturated score can never cross again.
    assign level_up  = (score_new / LEVEL_V) > (score / LEVEL_V);

    always_ff @(posedge clk10) begin
        if (clr || restart) begin
            state      <= IDLE;
            running    <= 1'b0;
            pass_pulse <= 1'b0;
            score      <= '0;
            speed      <= SPEED_INIT_V;
            for (int i = 0; i < N_TUBES; i++) begin
                tube_x[i*X_W +: X_W] <= X_W'(X_INIT0 + i*X_SPACING);
                tube_y[i*X_W +: X_W] <= Y_INIT_V;
            end
`ifdef TUBE_GAP_SHRINK_EN
            gap_half   <= X_W'(GAP_INIT);
`endif
        end else begin
            pass_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !game_end) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    for (int i = 0; i < N_TUBES; i++) begin
                        tube_x[i*X_W +: X_W] <= x_next[i];
                        tube_y[i*X_W +: X_W] <= y_next[i];
                    end
                    score      <= score_new;
                    pass_pulse <= (k != 4'd0);
                    if (level_up) begin
                        speed <= (speed < SPEED_MAX_V) ? speed + 5'd1 : speed;
`ifdef TUBE_GAP_SHRINK_EN
                        gap_half <= (gap_half >= X_W'(GAP_MIN + GAP_STEP))
                                    ? gap_half - X_W'(GAP_STEP) : X_W'(GAP_MIN);
`endif
                    end
                    if (game_end) begin
                        state   <= FROZEN;
                        running <= 1'b0;
                    end
                end
                FROZEN: begin
                    running <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tube_field_ctrl.sv
// tb/tb_tube_field_ctrl.sv - directed self-checking bench for tube_field_ctrl
module tb_tube_field_ctrl;

    logic        clk10 = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic        game_end = 1'b0;
    logic        start_b = 1'b0;

    logic [29:0] tube_x, tube_y, tube_x_b, tube_y_b;
    logic [7:0]  score;
    logic [4:0]  score_b;
    logic [4:0]  speed, speed_b;
    logic        pass_pulse, running, pass_pulse_b, running_b;
`ifdef TUBE_GAP_SHRINK_EN
    logic [9:0]  gap_half, gap_half_b;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] m_lfsr, m_prev;

    always #5 clk10 = ~clk10;

    tube_field_ctrl u_dut (
        .clk10      (clk10),
        .clr        (clr),
        .start      (start),
        .game_end   (game_end),
        .tube_x     (tube_x),
        .tube_y     (tube_y),
        .score      (score),
        .speed      (speed),
        .pass_pulse (pass_pulse),
        .running    (running)
`ifdef TUBE_GAP_SHRINK_EN
        ,.gap_half  (gap_half)
`endif
    );

    // All tubes stacked at x=404 so they respawn together; short levels and
    // a 5-bit score to reach the speed cap and saturation quickly.
    tube_field_ctrl #(
        .X_SPACING  (0),
        .LEVEL_STEP (3),
        .SCORE_W    (5)
    ) u_dut_b (
        .clk10      (clk10),
        .clr        (clr),
        .start      (start_b),
        .game_end   (1'b0),
        .tube_x     (tube_x_b),
        .tube_y     (tube_y_b),
        .score      (score_b),
        .speed      (speed_b),
        .pass_pulse (pass_pulse_b),
        .running    (running_b)
`ifdef TUBE_GAP_SHRINK_EN
        ,.gap_half  (gap_half_b)
`endif
    );

    // Reference LFSR; m_prev holds the value the DUT saw at the last edge.
    always @(posedge clk10) begin
        if (clr) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        m_prev <= m_lfsr;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk10);
        @(negedge clk10);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int n;
        int exp_v;
        logic [15:0] r;

        // Reset
        tick();
        clr = 1'b0;
        check("rst_x",       tube_x, {10'd904, 10'd654, 10'd404});
        check("rst_y",       tube_y, {10'd200, 10'd200, 10'd200});
        check("rst_score",   score, 0);
        check("rst_speed",   speed, 5);
        check("rst_running", running, 0);
        check("rst_pulse",   pass_pulse, 0);
        check("rst_x_b",     tube_x_b, {10'd404, 10'd404, 10'd404});
`ifdef TUBE_GAP_SHRINK_EN
        check("rst_gap",     gap_half, 60);
`endif

        // Start and scroll 10 cycles
        start = 1'b1; tick(); start = 1'b0;
        check("start_running", running, 1);
        check("start_x_hold",  tube_x, {10'd904, 10'd654, 10'd404});
        ticks(10);
        check("scroll_x", tube_x, {10'd854, 10'd604, 10'd354});

        // Freeze: the transition edge still moves, then everything holds
        game_end = 1'b1; tick();
        check("freeze_running", running, 0);
        check("freeze_x", tube_x, {10'd849, 10'd599, 10'd349});
        ticks(20);
        check("freeze_hold_x", tube_x, {10'd849, 10'd599, 10'd349});
        game_end = 1'b0; start = 1'b1; tick(); start = 1'b0;
        check("restart_x",       tube_x, {10'd904, 10'd654, 10'd404});
        check("restart_running", running, 0);
        check("restart_speed",   speed, 5);

        // start with game_end high in IDLE stays idle
        start = 1'b1; game_end = 1'b1; tick(); start = 1'b0; game_end = 1'b0;
        check("idle_both_running", running, 0);

        // Single respawn of tube 0
        start = 1'b1; tick(); start = 1'b0;
        ticks(58);
        check("pre_respawn_x0", tube_x[9:0], 114);
        check("pre_respawn_pulse", pass_pulse, 0);
        tick();
        check("respawn_x0",    tube_x[9:0], 904);
        check("respawn_x1",    tube_x[19:10], 359);
        exp_v = 150 + (m_prev & 16'h7F);
        check("respawn_y0",    tube_y[9:0], exp_v);
        check("respawn_y0_rng", (tube_y[9:0] >= 150) && (tube_y[9:0] <= 277), 1);
        check("respawn_y1",    tube_y[19:10], 200);
        check("respawn_score", score, 1);
        check("respawn_pulse", pass_pulse, 1);
        tick();
        check("pulse_one_cycle", pass_pulse, 0);

        // Level-up at score 10
        n = 0;
        while (score != 8'd9 && n < 2000) begin tick(); n++; end
        check("wait_score9", score, 9);
        check("speed_at_9", speed, 5);
        n = 0;
        while (score != 8'd10 && n < 400) begin tick(); n++; end
        check("wait_score10", score, 10);
        check("speed_at_10", speed, 6);
`ifdef TUBE_GAP_SHRINK_EN
        check("gap_at_10", gap_half, 56);
`endif

        // Reset overrides a respawn due on the same edge
        n = 0;
        while (!(tube_x[9:0] <= 114 || tube_x[19:10] <= 114 || tube_x[29:20] <= 114) && n < 400) begin
            tick(); n++;
        end
        check("wait_respawn_due", (tube_x[9:0] <= 114 || tube_x[19:10] <= 114 || tube_x[29:20] <= 114), 1);
        clr = 1'b1; tick(); clr = 1'b0;
        check("midrst_x",       tube_x, {10'd904, 10'd654, 10'd404});
        check("midrst_y",       tube_y, {10'd200, 10'd200, 10'd200});
        check("midrst_score",   score, 0);
        check("midrst_speed",   speed, 5);
        check("midrst_pulse",   pass_pulse, 0);
        check("midrst_running", running, 0);

        // Simultaneous respawns, level steps, caps and saturation
        start_b = 1'b1; tick(); start_b = 1'b0;
        for (int kk = 1; kk <= 12; kk++) begin
            n = 0;
            while (!pass_pulse_b && n < 400) begin tick(); n++; end
            check("b_wait_pulse", pass_pulse_b, 1);
            if (kk == 1) begin
                r = m_prev;
                check("b_x_all", tube_x_b, {10'd904, 10'd904, 10'd904});
                exp_v = 150 + (r & 16'h7F);
                check("b_y0", tube_y_b[9:0], exp_v);
                exp_v = 150 + ((r >> 1) & 16'h7F);
                check("b_y1", tube_y_b[19:10], exp_v);
                exp_v = 150 + ((r >> 2) & 16'h7F);
                check("b_y2", tube_y_b[29:20], exp_v);
            end
            exp_v = (3 * kk > 31) ? 31 : 3 * kk;
            check("b_score", score_b, exp_v);
            exp_v = (5 + kk > 12) ? 12 : 5 + kk;
            check("b_speed", speed_b, exp_v);
`ifdef TUBE_GAP_SHRINK_EN
            exp_v = (60 - 4 * kk < 32) ? 32 : 60 - 4 * kk;
            check("b_gap", gap_half_b, exp_v);
`endif
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
